// File: rtl/if_prefetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package if_prefetch_pkg;

  localparam int          SRAM_BUS_W    = 32;
  localparam int          SRAM_ADDR_W   = 32;
  localparam int          IF_FIFO_DEPTH = 2;

  localparam logic [31:0] INST_NOP      = 32'h0000_0013;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic        JUMP_ENABLE   = 1'b1;
  localparam logic        HOLD_ENABLE   = 1'b1;

  typedef struct packed {
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_BUS_W-1:0]  data;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_fifo.sv
// Small synchronous FIFO (the if_fifo block) with flush; used for the prefetch
// buffer and for the in-order address queue of outstanding reads.
module if_prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  assign pop_ok  = pop && !empty;
  // A full FIFO accepts a push only when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop_ok)      count_reg <= count_reg + 1'b1;
      else if (pop_ok && !push_ok) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_reg[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/if_prefetch.sv
// Fetch front end: owns the PC, issues SRAM word reads, buffers returns for IF/ID.
// Define IF_MISALIGN_CHK_EN to add misalign_o, flagging jumps to unaligned targets.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = IF_FIFO_DEPTH,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jump_flag_ex_i,
  input  logic [SRAM_ADDR_W-1:0] jump_addr_ex_i,
  input  logic                   hold_flag_ex_i,
  input  logic                   dm_halt_req_i,
  output logic                   mem_req_o,
  output logic [SRAM_ADDR_W-1:0] mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [SRAM_BUS_W-1:0]  mem_rdata_i,
  output logic [SRAM_BUS_W-1:0]  inst_o,
  output logic [SRAM_ADDR_W-1:0] inst_addr_o,
  output logic                   inst_valid_o
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic                   misalign_o
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OST_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = ((CNT_W > OST_W) ? CNT_W : OST_W) + 1;

  logic [SRAM_ADDR_W-1:0] fetch_pc_reg;
  logic [OST_W-1:0]       drop_cnt_reg;
  logic [OST_W-1:0]       outstanding;
  logic [CNT_W-1:0]       fifo_count;
  logic [SUM_W-1:0]       inflight;
  logic                   fifo_full, fifo_empty, aq_full, aq_empty;
  logic [SRAM_ADDR_W-1:0] aq_head;
  fetch_entry_t           push_entry, head_entry;
  logic                   in_rst, jump, grant, rvalid_eff, fifo_push, fifo_pop;

  assign in_rst   = (rst == RST_ENABLE);
  assign jump     = (jump_flag_ex_i == JUMP_ENABLE);
  assign inflight = SUM_W'(outstanding) + SUM_W'(fifo_count);

  // Every outstanding read owns a FIFO slot, so the buffer cannot overflow.
  assign mem_req_o  = !in_rst && !dm_halt_req_i && !jump &&
                      (inflight < SUM_W'(FIFO_DEPTH)) && !aq_full;
  assign mem_addr_o = fetch_pc_reg;
  assign grant      = mem_req_o && mem_gnt_i;

  // With nothing outstanding (e.g. straight after reset) rvalid is stale noise.
  assign rvalid_eff = mem_rvalid_i && !aq_empty;
  assign fifo_pop   = !fifo_empty && (hold_flag_ex_i != HOLD_ENABLE) &&
                      !dm_halt_req_i && !jump;
  assign fifo_push  = rvalid_eff && (drop_cnt_reg == '0) && !jump &&
                      (!fifo_full || fifo_pop);
  assign push_entry = '{addr: aq_head, data: mem_rdata_i};

  // Address queue: its occupancy is the count of granted-but-unreturned reads.
  if_prefetch_fifo #(
    .WIDTH (SRAM_ADDR_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_addr_q (
    .clk       (clk),
    .rst       (in_rst),
    .flush     (1'b0),
    .push      (grant),
    .push_data (fetch_pc_reg),
    .pop       (rvalid_eff),
    .head      (aq_head),
    .count     (outstanding),
    .full      (aq_full),
    .empty     (aq_empty)
  );

  if_prefetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_inst_q (
    .clk       (clk),
    .rst       (in_rst),
    .flush     (jump),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign inst_valid_o = !fifo_empty;
  assign inst_o       = fifo_empty ? INST_NOP  : head_entry.data;
  assign inst_addr_o  = fifo_empty ? ZERO_WORD : head_entry.addr;

  always_ff @(posedge clk) begin
    if (in_rst) begin
      fetch_pc_reg <= RESET_PC;
      drop_cnt_reg <= '0;
    end else if (jump) begin
      fetch_pc_reg <= jump_addr_ex_i & ~32'h3;
      // Reads still in flight belong to the old stream and must be discarded.
      drop_cnt_reg <= outstanding - OST_W'(rvalid_eff);
    end else begin
      if (grant) fetch_pc_reg <= fetch_pc_reg + 32'd4;
      if (rvalid_eff && (drop_cnt_reg != '0)) drop_cnt_reg <= drop_cnt_reg - 1'b1;
    end
  end

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_reg;

  always_ff @(posedge clk) begin
    if (in_rst)    misalign_reg <= 1'b0;
    else if (jump) misalign_reg <= |jump_addr_ex_i[1:0];
  end

  assign misalign_o = misalign_reg;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: a scripted SRAM responder plus cycle-by-cycle checks.
module tb_if_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag_ex_i;
  logic [31:0] jump_addr_ex_i;
  logic        hold_flag_ex_i;
  logic        dm_halt_req_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
`ifdef IF_MISALIGN_CHK_EN
  logic        misalign_o;
`endif

  int          total = 0;
  int          bad   = 0;
  int          n_gnt = 0;
  logic [31:0] last_gnt = 32'h0;
  logic        rsp_en = 1'b1;
  logic [31:0] pend_q[$];

  always #5 clk = ~clk;

  if_prefetch dut (
`ifdef IF_MISALIGN_CHK_EN
    .misalign_o     (misalign_o),
`endif
    .clk            (clk),
    .rst            (rst),
    .jump_flag_ex_i (jump_flag_ex_i),
    .jump_addr_ex_i (jump_addr_ex_i),
    .hold_flag_ex_i (hold_flag_ex_i),
    .dm_halt_req_i  (dm_halt_req_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .inst_o         (inst_o),
    .inst_addr_o    (inst_addr_o),
    .inst_valid_o   (inst_valid_o)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: SRAM always grants, returns in order when rsp_en, 1-cycle minimum latency.
  task automatic tick();
    @(negedge clk);
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = rsp_en && (pend_q.size() > 0);
    mem_rdata_i  = 32'h0;
    if (mem_rvalid_i) mem_rdata_i = data_of(pend_q[0]);
    #1;
    if (mem_rvalid_i) void'(pend_q.pop_front());
    if (mem_req_o && mem_gnt_i) begin
      n_gnt++;
      last_gnt = mem_addr_o;
      pend_q.push_back(mem_addr_o);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; jump_flag_ex_i = 1'b0; jump_addr_ex_i = 32'h0;
    hold_flag_ex_i = 1'b0; dm_halt_req_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;

    // Reset state
    tick(); tick();
    chk("rst_req",   mem_req_o,    32'h0);
    chk("rst_addr",  mem_addr_o,   32'h0);
    chk("rst_valid", inst_valid_o, 32'h0);
    chk("rst_inst",  inst_o,       32'h0000_0013);
    chk("rst_iaddr", inst_addr_o,  32'h0);
`ifdef IF_MISALIGN_CHK_EN
    chk("rst_misalign", misalign_o, 32'h0);
`endif
    rst = 1'b0;

    // Streaming with 1-cycle SRAM
    tick(); chk("s1_t1_valid", inst_valid_o, 32'h0);
    tick(); chk("s1_t2_valid", inst_valid_o, 32'h1);
            chk("s1_t2_iaddr", inst_addr_o, 32'h0);
            chk("s1_t2_inst",  inst_o, data_of(32'h0));
    tick(); chk("s1_t3_iaddr", inst_addr_o, 32'h4);
    tick(); chk("s1_t4_valid", inst_valid_o, 32'h0);
    tick(); chk("s1_t5_iaddr", inst_addr_o, 32'h8);
            chk("s1_t5_inst",  inst_o, data_of(32'h8));
            chk("s1_ngnt",     n_gnt, 32'd4);
            chk("s1_lastgnt",  last_gnt, 32'hC);
            chk("s1_pc",       mem_addr_o, 32'h10);

    // Hold for 5 cycles
    hold_flag_ex_i = 1'b1;
    tick(); chk("s2_t6_iaddr", inst_addr_o, 32'h8);
            chk("s2_t6_req",   mem_req_o, 32'h0);
    repeat (4) tick();
    chk("s2_t10_iaddr", inst_addr_o, 32'h8);
    chk("s2_t10_inst",  inst_o, data_of(32'h8));
    chk("s2_t10_req",   mem_req_o, 32'h0);
    chk("s2_t10_pc",    mem_addr_o, 32'h10);
    chk("s2_t10_ngnt",  n_gnt, 32'd4);
    hold_flag_ex_i = 1'b0;
    tick(); chk("s2_t11_iaddr", inst_addr_o, 32'hC);
    tick(); chk("s2_t12_valid", inst_valid_o, 32'h0);
    tick(); chk("s2_t13_iaddr", inst_addr_o, 32'h10);

    // Jump with two reads outstanding
    rsp_en = 1'b0;
    tick();
    tick(); chk("s3_t15_lastgnt", last_gnt, 32'h18);
            chk("s3_t15_req",     mem_req_o, 32'h0);
    jump_flag_ex_i = 1'b1; jump_addr_ex_i = 32'h100;
    tick(); chk("s3_t16_valid", inst_valid_o, 32'h0);
            chk("s3_t16_pc",    mem_addr_o, 32'h100);
    jump_flag_ex_i = 1'b0; rsp_en = 1'b1;
    tick(); chk("s3_t17_valid",   inst_valid_o, 32'h0);
    tick(); chk("s3_t18_valid",   inst_valid_o, 32'h0);
            chk("s3_t18_lastgnt", last_gnt, 32'h100);
    tick(); chk("s3_t19_iaddr",   inst_addr_o, 32'h100);
            chk("s3_t19_inst",    inst_o, data_of(32'h100));

    // Jump + hold + rvalid in the same cycle
    rsp_en = 1'b0;
    tick();
    tick(); chk("s4_t21_lastgnt", last_gnt, 32'h108);
    jump_flag_ex_i = 1'b1; jump_addr_ex_i = 32'h100; hold_flag_ex_i = 1'b1; rsp_en = 1'b1;
    tick(); chk("s4_t22_valid", inst_valid_o, 32'h0);
    jump_flag_ex_i = 1'b0; hold_flag_ex_i = 1'b0;
    tick(); chk("s4_t23_valid",   inst_valid_o, 32'h0);
            chk("s4_t23_lastgnt", last_gnt, 32'h100);
    tick(); chk("s4_t24_valid",   inst_valid_o, 32'h1);
            chk("s4_t24_iaddr",   inst_addr_o, 32'h100);

    // Debug halt mid-stream
    dm_halt_req_i = 1'b1;
    tick(); chk("s5_t25_iaddr", inst_addr_o, 32'h100);
            chk("s5_t25_req",   mem_req_o, 32'h0);
    tick(); tick();
    chk("s5_t27_iaddr", inst_addr_o, 32'h100);
    chk("s5_t27_ngnt",  n_gnt, 32'd12);
    chk("s5_t27_pc",    mem_addr_o, 32'h108);
    dm_halt_req_i = 1'b0;
    tick(); chk("s5_t28_iaddr",   inst_addr_o, 32'h104);
    tick(); chk("s5_t29_valid",   inst_valid_o, 32'h0);
            chk("s5_t29_lastgnt", last_gnt, 32'h108);
    tick(); chk("s5_t30_iaddr",   inst_addr_o, 32'h108);

    // Reset mid-transfer, late rvalid afterwards
    rsp_en = 1'b0; rst = 1'b1;
    tick(); chk("s6_t31_valid", inst_valid_o, 32'h0);
            chk("s6_t31_req",   mem_req_o, 32'h0);
            chk("s6_t31_pc",    mem_addr_o, 32'h0);
    rst = 1'b0; rsp_en = 1'b1;
    tick(); chk("s6_t32_valid",   inst_valid_o, 32'h0);
            chk("s6_t32_lastgnt", last_gnt, 32'h0);
    tick(); chk("s6_t33_iaddr",   inst_addr_o, 32'h0);
            chk("s6_t33_inst",    inst_o, data_of(32'h0));

    // Unaligned jump near the top of memory, PC wrap, then an aligned jump
    jump_flag_ex_i = 1'b1; jump_addr_ex_i = 32'hFFFF_FFFE; rsp_en = 1'b0;
    tick(); chk("s7_t34_pc",    mem_addr_o, 32'hFFFF_FFFC);
            chk("s7_t34_valid", inst_valid_o, 32'h0);
`ifdef IF_MISALIGN_CHK_EN
            chk("s7_t34_misalign", misalign_o, 32'h1);
`endif
    jump_flag_ex_i = 1'b0; rsp_en = 1'b1;
    tick(); chk("s7_t35_pc",      mem_addr_o, 32'h0);
            chk("s7_t35_lastgnt", last_gnt, 32'hFFFF_FFFC);
            chk("s7_t35_valid",   inst_valid_o, 32'h0);
    tick(); chk("s7_t36_iaddr",   inst_addr_o, 32'hFFFF_FFFC);
            chk("s7_t36_inst",    inst_o, data_of(32'hFFFF_FFFC));
    jump_flag_ex_i = 1'b1; jump_addr_ex_i = 32'h200;
    tick(); chk("s7_t37_valid", inst_valid_o, 32'h0);
            chk("s7_t37_pc",    mem_addr_o, 32'h200);
`ifdef IF_MISALIGN_CHK_EN
            chk("s7_t37_misalign", misalign_o, 32'h0);
`endif
    jump_flag_ex_i = 1'b0;
    tick();
    tick(); chk("s7_t39_iaddr", inst_addr_o, 32'h200);
            chk("s7_t39_inst",  inst_o, data_of(32'h200));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
